// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain
// Description : Drains an upstream FIFO into a 2-entry valid/ready output
//               buffer; optional performance counters (FIFO_DRAIN_PERF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_enb,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  err_underflow,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    // Encoding doubles as the buffer occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [DATA_WIDTH-1:0] w_buf0_nxt;
    logic [DATA_WIDTH-1:0] w_buf1_nxt;
    logic                  r_err;
    logic                  w_pop;
    logic [1:0]            w_occ;
    logic [2:0]            w_pending;

    assign m_valid       = (r_state != S_EMPTY);
    assign m_data        = r_buf0;
    assign err_underflow = r_err;
    assign w_pop         = m_valid & m_ready;
    assign w_occ         = r_state;

    // Words held plus word on the way, minus the one leaving this cycle.
    assign w_pending   = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd_enb = ~fifo_empty & ~flush & rst_n & (w_pending < 3'd2);

    always_comb begin
        w_state_nxt = r_state;
        w_buf0_nxt  = r_buf0;
        w_buf1_nxt  = r_buf1;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (r_inflight) begin
                        w_state_nxt = S_ONE;
                        w_buf0_nxt  = fifo_data;
                    end
                end
                S_ONE: begin
                    case ({r_inflight, w_pop})
                        2'b10: begin
                            w_state_nxt = S_TWO;
                            w_buf1_nxt  = fifo_data;
                        end
                        2'b01: w_state_nxt = S_EMPTY;
                        2'b11: w_buf0_nxt  = fifo_data;
                        default: ;
                    endcase
                end
                S_TWO: begin
                    if (w_pop) begin
                        w_buf0_nxt = r_buf1;
                        if (r_inflight) begin
                            w_buf1_nxt = fifo_data;
                        end else begin
                            w_state_nxt = S_ONE;
                        end
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= fifo_rd_enb;
            r_buf0     <= w_buf0_nxt;
            r_buf1     <= w_buf1_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (fifo_underflow) begin
            r_err <= 1'b1;
        end
    end

`ifdef FIFO_DRAIN_PERF_EN
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_word_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    // Saturating counters; flush intentionally leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop && (r_word_cnt != c_CNT_MAX)) begin
                r_word_cnt <= r_word_cnt + c_CNT_ONE;
            end
            if (m_valid && !m_ready && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
        end
    end

    assign word_cnt  = r_word_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign word_cnt  = '0;
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain.sv
`default_nettype none
// Testbench for fifo_drain: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fifo_drain;
    localparam int DW   = 8;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;
`ifdef FIFO_DRAIN_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_underflow = 1'b0;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_enb;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          err_underflow;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_underflow(fifo_underflow),
        .fifo_data     (fifo_data),
        .fifo_rd_enb   (fifo_rd_enb),
        .flush         (flush),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .err_underflow (err_underflow),
        .word_cnt      (word_cnt),
        .stall_cnt     (stall_cnt)
    );

    typedef struct {
        bit          rdy;
        bit          fl;
        bit          e_rd;
        bit          e_val;
        logic [7:0]  e_data;
    } vec_t;

    vec_t tbl [25];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: upstream FIFO contents, output buffer, word in flight.
    logic [DW-1:0] src[$];
    logic [DW-1:0] q[$];
    bit            infl = 1'b0;
    logic [DW-1:0] inword = '0;
    bit            m_err = 1'b0;
    int            m_wcnt = 0;
    int            m_scnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int exp_cnt(input int v);
        return PERF ? v : 0;
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    task automatic cycle(input bit rdy, input bit fl, input bit uf, input bit hold_empty);
        bit ev;
        bit pop;
        bit erd;
        @(negedge clk);
        m_ready        = rdy;
        flush          = fl;
        fifo_underflow = uf;
        fifo_empty     = (src.size() == 0) || hold_empty;
        fifo_data      = infl ? inword : DW'($urandom);
        #1;
        ev  = (q.size() != 0);
        pop = ev && rdy;
        erd = !fifo_empty && !fl && ((q.size() + int'(infl) - int'(pop)) < 2);
        chk("m_valid", m_valid, ev);
        if (ev) chk("m_data", m_data, q[0]);
        chk("fifo_rd_enb", fifo_rd_enb, erd);
        chk("err_underflow", err_underflow, m_err);
        chk("word_cnt", word_cnt, exp_cnt(m_wcnt));
        chk("stall_cnt", stall_cnt, exp_cnt(m_scnt));
        if (pop) begin
            void'(q.pop_front());
            m_wcnt = sat(m_wcnt);
        end
        if (ev && !rdy) m_scnt = sat(m_scnt);
        if (uf) m_err = 1'b1;
        if (fl) begin
            q.delete();
            infl = 1'b0;
        end else begin
            if (infl) q.push_back(inword);
            infl = erd;
            if (erd) inword = src.pop_front();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_fifo_rd_enb", fifo_rd_enb, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        fifo_empty     = 1'b1;
        flush          = 1'b0;
        m_ready        = 1'b0;
        fifo_underflow = 1'b0;
        q.delete();
        infl   = 1'b0;
        m_err  = 1'b0;
        m_wcnt = 0;
        m_scnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_rows(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            cycle(tbl[i].rdy, tbl[i].fl, 1'b0, 1'b0);
            chk($sformatf("vec%0d_rd", i), fifo_rd_enb, tbl[i].e_rd);
            chk($sformatf("vec%0d_valid", i), m_valid, tbl[i].e_val);
            if (tbl[i].e_val) chk($sformatf("vec%0d_data", i), m_data, tbl[i].e_data);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] nxt;
        bit            found;
        int            n_sat;

        tbl = '{
            // 3 words, m_ready=1
            '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
            '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
            '{1'b1, 1'b0, 1'b1, 1'b1, 8'h11},
            '{1'b1, 1'b0, 1'b0, 1'b1, 8'h22},
            '{1'b1, 1'b0, 1'b0, 1'b1, 8'h33},
            '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00},
            // 4 words, backpressure then release
            '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
            '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA1},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA1},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA1},
            '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA1},
            '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA2},
            '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA3},
            '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA4},
            '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00},
            // fill to TWO, flush with pop, then drain the rest
            '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
            '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'hB1},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'hB1},
            '{1'b1, 1'b1, 1'b0, 1'b1, 8'hB1},
            '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
            '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00},
            '{1'b1, 1'b0, 1'b0, 1'b1, 8'hB3},
            '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00}
        };

        do_reset();
        src = '{8'h11, 8'h22, 8'h33};
        run_rows(0, 5);
        chk("seg1_word_cnt", word_cnt, exp_cnt(3));
        chk("seg1_stall_cnt", stall_cnt, exp_cnt(0));

        do_reset();
        src = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        run_rows(6, 15);
        chk("seg2_word_cnt", word_cnt, exp_cnt(4));
        chk("seg2_stall_cnt", stall_cnt, exp_cnt(3));

        do_reset();
        src = '{8'hB1, 8'hB2, 8'hB3};
        run_rows(16, 21);
        chk("flush_word_cnt", word_cnt, exp_cnt(1));
        chk("flush_stall_cnt", stall_cnt, exp_cnt(2));
        run_rows(22, 24);

        // Sticky underflow survives flush, cleared only by reset.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("err_set", err_underflow, 1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("err_after_flush", err_underflow, 1);
        do_reset();
        chk("err_after_reset", err_underflow, 0);

        // Reset while a word is in flight: that word must not reappear.
        src = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_inflight", {63'd0, infl}, 1);
        nxt = src[0];
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (m_valid) found = 1'b1;
        end
        chk("post_rst_valid", {63'd0, found}, 1);
        if (found) chk("post_rst_first", m_data, nxt);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if (src.size() < 4) src.push_back(DW'($urandom));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 300) == 0, $urandom_range(0, 4) == 0);
        end

        // Long stall: counter saturation (or constant zero without counters).
        do_reset();
        src.delete();
        src.push_back(8'h5A);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_sat = PERF ? (1 << CW) + 5 : 300;
        repeat (n_sat) @(posedge clk);
        @(negedge clk);
        #1;
        chk("sat_stall_cnt", stall_cnt, PERF ? CMAX : 0);
        chk("sat_word_cnt", word_cnt, 0);
        chk("sat_valid", m_valid, 1);
        chk("sat_data", m_data, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of FIFO read data and output data.
REQ-002 Parameter CNT_WIDTH, default 16: width of performance counters.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_underflow  input  1  upstream FIFO underflow flag.
REQ-007 fifo_data  input  DATA_WIDTH  upstream FIFO read data, valid the cycle after fifo_rd_enb.
REQ-008 fifo_rd_enb  output  1  read strobe to upstream FIFO.
REQ-009 flush  input  1  synchronous discard of buffered and in-flight data.
REQ-010 m_valid  output  1  downstream data valid.
REQ-011 m_ready  input  1  downstream ready.
REQ-012 m_data  output  DATA_WIDTH  downstream data, oldest buffered word.
REQ-013 err_underflow  output  1  sticky underflow error.
REQ-014 word_cnt  output  CNT_WIDTH  delivered-word counter.
REQ-015 stall_cnt  output  CNT_WIDTH  backpressure-cycle counter.

Function
REQ-016 The block SHALL hold a 2-entry in-order output buffer with occupancy state EMPTY/ONE/TWO and a 1-bit in-flight flag.
REQ-017 Transfer: m_valid && m_ready in same cycle (pop); m_valid SHALL equal (state != EMPTY) and be registered-state only.
REQ-018 fifo_rd_enb SHALL = !fifo_empty && !flush && rst_n && (occ + inflight - pop < 2); the m_ready-to-fifo_rd_enb combinational path is part of the design.
REQ-019 inflight SHALL be set the cycle after fifo_rd_enb=1 and clear when no new read is issued; the word on fifo_data SHALL be written to the buffer tail that cycle.
REQ-020 Transitions: EMPTY->ONE on arrival without pop; ONE->TWO on arrival without pop; ONE->EMPTY on pop without arrival; TWO->ONE on pop; arrival+pop keeps state.
REQ-021 Sustained throughput SHALL be one word per cycle when fifo_empty=0 and m_ready=1.
REQ-022 m_data and m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-023 flush=1: a pop in that cycle completes and counts; next cycle state=EMPTY, in-flight word discarded, fifo_rd_enb=0 during flush.
REQ-024 Word order SHALL equal FIFO read order; no word dropped or duplicated except by flush.
REQ-025 fifo_underflow=1 on any edge SHALL set err_underflow, cleared only by reset.

Reset
REQ-026 rst_n low SHALL immediately force state=EMPTY, inflight=0, m_valid=0, m_data=0, fifo_rd_enb=0, err_underflow=0, word_cnt=0, stall_cnt=0.
REQ-027 Reset mid-transfer SHALL discard all buffered and in-flight data; first read issues the first edge after release with fifo_empty=0.

Configuration
REQ-028 Macro FIFO_DRAIN_PERF_EN defined: word_cnt increments per pop, stall_cnt per m_valid && !m_ready cycle, both saturate at all-ones, not cleared by flush.
REQ-029 FIFO_DRAIN_PERF_EN undefined: counter logic SHALL be absent, word_cnt and stall_cnt tied to 0, ports unchanged.

Verification
REQ-030 FIFO holds 0x11,0x22,0x33, m_ready=1 -> fifo_rd_enb 3 consecutive cycles, m_data 0x11,0x22,0x33 on consecutive cycles, first m_valid 2 cycles after first fifo_rd_enb.
REQ-031 FIFO holds 4 words, m_ready=0 -> exactly 2 reads issued, state=TWO, m_data=first word held stable; m_ready=1 -> remaining 2 words delivered in order, no gaps.
REQ-032 State TWO, inflight=0, assert flush one cycle with m_ready=1 -> first word counted, next cycle m_valid=0; with PERF, word_cnt=1.
REQ-033 Pulse fifo_underflow one cycle -> err_underflow=1 and holds through flush; deasserts only on rst_n low.
REQ-034 rst_n low during stream with inflight=1 -> all outputs 0 asynchronously; post-release first delivered word is the next FIFO word, not the discarded one.
REQ-035 PERF build, m_ready=0 for 2^CNT_WIDTH+5 cycles with m_valid=1 -> stall_cnt saturates at all-ones; non-PERF build -> both counters read 0.
